if_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode-stage controller.
- Owns the fetch PC and drives a request/ready instruction-memory port.
- Presents instr_d, pc_d and pcplus4_d to decode; the controller and immediate logic slice opcode/funct/rd/rs1/imm from instr_d.
- Handles stall from hazard logic, flush, and PC redirect from the decode-stage branch/jump resolution (pcsrc).

---
 rtl/if_stage.sv | 189 ++++++++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IF/ID pipeline register.
// Owns the fetch PC. It drives a req/ready instruction-memory port and
// presents instr_d / pc_d / pcplus4_d / valid_d to the decode stage.
// It handles stall_f, flush_d, and redirects from decode, including a
// redirect that arrives while a fetch is still waiting for imem_ready.
// Optional feature macro: FETCH_STAT_EN. When defined, the block adds
// the fetch_cnt and bubble_cnt statistics outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic        r_drop_pending;
  logic [31:0] r_redir_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;

  logic [31:0] w_redir_target;
  logic        w_load_new;
  logic [31:0] w_new_instr;
  logic [31:0] w_new_pc;
  logic [31:0] w_new_pcplus4;

  // The address stays on r_pc_f until the request is accepted.
  // A redirect is therefore parked in r_redir_pc instead of moving the PC.
  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc_f;

  assign instr_d   = r_instr_d;
  assign pc_d      = r_pc_d;
  assign pcplus4_d = r_pcplus4_d;
  assign valid_d   = r_valid_d;

  // Select what IF/ID would load this cycle: a live response or the hold buffer
  always_comb begin
    w_redir_target = redirect_pc & ~32'h0000_0003;
    w_load_new     = 1'b0;
    w_new_instr    = imem_rdata;
    w_new_pc       = r_pc_f;
    case (r_state)
      S_FETCH: begin
        if (imem_ready && !redirect && !r_drop_pending && !stall_f) begin
          w_load_new = 1'b1;
        end
      end
      S_HOLD: begin
        if (!redirect && !stall_f) begin
          w_load_new  = 1'b1;
          w_new_instr = r_hold_instr;
          w_new_pc    = r_hold_pc;
        end
      end
      default: begin
        w_load_new = 1'b0;
      end
    endcase
    w_new_pcplus4 = w_new_pc + 32'd4;
  end

  // Fetch FSM: PC sequencing, pending-redirect tracking, and the stall hold buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_BOOT;
      r_pc_f         <= RESET_PC;
      r_drop_pending <= 1'b0;
      r_redir_pc     <= 32'h0;
      r_hold_instr   <= NOP_INSTR;
      r_hold_pc      <= 32'h0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            if (redirect || r_drop_pending) begin
              // The response belongs to the wrong path. The live redirect wins.
              r_pc_f         <= redirect ? w_redir_target : r_redir_pc;
              r_drop_pending <= 1'b0;
            end else if (stall_f) begin
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= r_pc_f;
              r_state      <= S_HOLD;
            end else begin
              r_pc_f <= r_pc_f + 32'd4;
            end
          end else if (redirect) begin
            // A later redirect before ready simply overwrites the target.
            r_redir_pc     <= w_redir_target;
            r_drop_pending <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc_f  <= w_redir_target;
            r_state <= S_FETCH;
          end else if (!stall_f) begin
            r_pc_f  <= r_hold_pc + 32'd4;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  // IF/ID register: priority is flush, then stall, then new data, then bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= 32'h0;
      r_pcplus4_d <= 32'h0;
      r_valid_d   <= 1'b0;
    end else if (flush_d) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (stall_f) begin
      r_instr_d <= r_instr_d;
    end else if (w_load_new) begin
      r_instr_d   <= w_new_instr;
      r_pc_d      <= w_new_pc;
      r_pcplus4_d <= w_new_pcplus4;
      r_valid_d   <= 1'b1;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // Count valid IF/ID loads, and bubble or flush loads, with free-running wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt  <= 32'h0;
      r_bubble_cnt <= 32'h0;
    end else if (flush_d) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else if (!stall_f) begin
      if (w_load_new) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// dut uses the default RESET_PC. dut_w starts at 0xFFFFFFF8 to exercise PC wrap.
// Both instances see a memory that returns instruction == address.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall_f;
  logic        flush_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  logic        reset_w;
  logic        zero_w = 1'b0;
  logic        one_w = 1'b1;
  logic [31:0] zero32_w = 32'h0;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic [31:0] instr_d_w;
  logic [31:0] pc_d_w;
  logic [31:0] pcplus4_d_w;
  logic        valid_d_w;

`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt_w, bubble_cnt_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  assign imem_rdata   = imem_addr;
  assign imem_rdata_w = imem_addr_w;

  if_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
    .pcplus4_d(pcplus4_d), .valid_d(valid_d)
`ifdef FETCH_STAT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset_w), .stall_f(zero_w), .flush_d(zero_w),
    .redirect(zero_w), .redirect_pc(zero32_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ready(one_w),
    .imem_rdata(imem_rdata_w), .instr_d(instr_d_w), .pc_d(pc_d_w),
    .pcplus4_d(pcplus4_d_w), .valid_d(valid_d_w)
`ifdef FETCH_STAT_EN
    , .fetch_cnt(fetch_cnt_w), .bubble_cnt(bubble_cnt_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc_d=%h instr_d=%h valid_d=%b req=%b addr=%h",
             $time, pc_d, instr_d, valid_d, imem_req, imem_addr);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_f = 1'b0; flush_d = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_ready = 1'b1; reset_w = 1'b0;
    tick();
    n_cmp++; if (instr_d !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h want %h", instr_d, NOP); end
    n_cmp++; if (pc_d !== 32'h0) begin n_bad++; $display("FAIL rst_pc_d: got %h want 0", pc_d); end
    n_cmp++; if (pcplus4_d !== 32'h0) begin n_bad++; $display("FAIL rst_pcplus4: got %h want 0", pcplus4_d); end
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_d); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL fetch_addr0: got %h want 0", imem_addr); end
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL boot_valid: got %b want 0", valid_d); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (pc_d !== 32'(4 * i)) begin n_bad++; $display("FAIL zw_pc_d[%0d]: got %h want %h", i, pc_d, 32'(4 * i)); end
      n_cmp++; if (pcplus4_d !== 32'(4 * i + 4)) begin n_bad++; $display("FAIL zw_pcplus4[%0d]: got %h want %h", i, pcplus4_d, 32'(4 * i + 4)); end
      n_cmp++; if (instr_d !== 32'(4 * i)) begin n_bad++; $display("FAIL zw_instr[%0d]: got %h want %h", i, instr_d, 32'(4 * i)); end
      n_cmp++; if (valid_d !== 1'b1) begin n_bad++; $display("FAIL zw_valid[%0d]: got %b want 1", i, valid_d); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      imem_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
        tick();
        n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL ws_valid[%0d.%0d]: got %b want 0", k, w, valid_d); end
        n_cmp++; if (instr_d !== NOP) begin n_bad++; $display("FAIL ws_instr[%0d.%0d]: got %h want %h", k, w, instr_d, NOP); end
        n_cmp++; if (imem_addr !== 32'(8 + 4 * k)) begin n_bad++; $display("FAIL ws_addr[%0d.%0d]: got %h want %h", k, w, imem_addr, 32'(8 + 4 * k)); end
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL ws_req[%0d.%0d]: got %b want 1", k, w, imem_req); end
      end
      imem_ready = 1'b1;
      tick();
      n_cmp++; if (valid_d !== 1'b1) begin n_bad++; $display("FAIL ws_valid_rdy[%0d]: got %b want 1", k, valid_d); end
      n_cmp++; if (pc_d !== 32'(8 + 4 * k)) begin n_bad++; $display("FAIL ws_pc_d[%0d]: got %h want %h", k, pc_d, 32'(8 + 4 * k)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (pc_d !== 32'hC) begin n_bad++; $display("FAIL st_pre_pc_d: got %h want c", pc_d); end
    stall_f = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_cmp++; if (pc_d !== 32'hC) begin n_bad++; $display("FAIL st_hold_pc_d[%0d]: got %h want c", s, pc_d); end
      n_cmp++; if (valid_d !== 1'b1) begin n_bad++; $display("FAIL st_hold_valid[%0d]: got %b want 1", s, valid_d); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL st_hold_req[%0d]: got %b want 0", s, imem_req); end
    end
    stall_f = 1'b0;
    tick();
    n_cmp++; if (pc_d !== 32'h10) begin n_bad++; $display("FAIL st_rel_pc_d: got %h want 10", pc_d); end
    n_cmp++; if (instr_d !== 32'h10) begin n_bad++; $display("FAIL st_rel_instr: got %h want 10", instr_d); end
    n_cmp++; if (imem_addr !== 32'h14) begin n_bad++; $display("FAIL st_rel_addr: got %h want 14", imem_addr); end
    tick();
    n_cmp++; if (pc_d !== 32'h14) begin n_bad++; $display("FAIL st_next_pc_d: got %h want 14", pc_d); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_ready = 1'b1;
    repeat (8) tick();
    imem_ready = 1'b0;
    tick();
    n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL rd_wait_addr: got %h want 20", imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL rd_addr_held: got %h want 20", imem_addr); end
    tick();
    n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL rd_addr_held2: got %h want 20", imem_addr); end
    imem_ready = 1'b1;
    tick();
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL rd_discard_valid: got %b want 0", valid_d); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_new_addr: got %h want 100", imem_addr); end
    tick();
    n_cmp++; if (pc_d !== 32'h100 || valid_d !== 1'b1) begin n_bad++; $display("FAIL rd_pc_d: got %h/%b want 100/1", pc_d, valid_d); end
    n_cmp++; if (pcplus4_d !== 32'h104) begin n_bad++; $display("FAIL rd_pcplus4: got %h want 104", pcplus4_d); end
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL rd_live_valid: got %b want 0", valid_d); end
    n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL rd_live_addr: got %h want 200", imem_addr); end
    tick();
    n_cmp++; if (pc_d !== 32'h200 || valid_d !== 1'b1) begin n_bad++; $display("FAIL rd_live_pc_d: got %h/%b want 200/1", pc_d, valid_d); end
  endtask

  task automatic test_flush();
    flush_d = 1'b1; stall_f = 1'b1;
    tick();
    flush_d = 1'b0; stall_f = 1'b0;
    n_cmp++; if (valid_d !== 1'b0) begin n_bad++; $display("FAIL fl_valid: got %b want 0", valid_d); end
    n_cmp++; if (instr_d !== NOP) begin n_bad++; $display("FAIL fl_instr: got %h want %h", instr_d, NOP); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL fl_req: got %b want 0", imem_req); end
    tick();
    n_cmp++; if (pc_d !== 32'h204 || valid_d !== 1'b1) begin n_bad++; $display("FAIL fl_resume: got %h/%b want 204/1", pc_d, valid_d); end
  endtask

  task automatic test_wrap();
    reset_w = 1'b1;
    tick();
    n_cmp++; if (imem_addr_w !== 32'hFFFF_FFF8 || imem_req_w !== 1'b1) begin n_bad++; $display("FAIL wr_addr: got %h/%b want fffffff8/1", imem_addr_w, imem_req_w); end
    tick();
    n_cmp++; if (pc_d_w !== 32'hFFFF_FFF8 || pcplus4_d_w !== 32'hFFFF_FFFC || valid_d_w !== 1'b1) begin n_bad++; $display("FAIL wr_0: got %h/%h/%b want fffffff8/fffffffc/1", pc_d_w, pcplus4_d_w, valid_d_w); end
    tick();
    n_cmp++; if (pc_d_w !== 32'hFFFF_FFFC || pcplus4_d_w !== 32'h0) begin n_bad++; $display("FAIL wr_1: got %h/%h want fffffffc/0", pc_d_w, pcplus4_d_w); end
    tick();
    n_cmp++; if (pc_d_w !== 32'h0 || pcplus4_d_w !== 32'h4 || instr_d_w !== 32'h0) begin n_bad++; $display("FAIL wr_2: got %h/%h/%h want 0/4/0", pc_d_w, pcplus4_d_w, instr_d_w); end
  endtask

  task automatic test_async_reset();
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL ar_pre_req: got %b want 1", imem_req); end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL ar_req: got %b want 0", imem_req); end
    n_cmp++; if (valid_d !== 1'b0 || instr_d !== NOP) begin n_bad++; $display("FAIL ar_ifid: got %b/%h want 0/%h", valid_d, instr_d, NOP); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL ar_addr: got %h want 0", imem_addr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
